weight_loader: RTL and testbench
================================

# weight_loader

Run-time programmable weight store for the DND MLP. It accepts a stream of signed weight words over a valid/ready configuration port and fills a register bank. The bank drives `weights_n1_mag`, `weights_n1_pol` and `weights_n2` with the same packed shapes the MLP datapath consumes from the hardwired table, so that table can be replaced by loaded weights without touching the datapath.

## Interface
- `N1`, 98: first-layer inputs; per-neuron mag/pol vectors hold N1/2+1 = 50 entries.
- `N2`, 10: hidden neurons; the n2 vector holds N2+1 = 11 entries.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_start` in 1: one-cycle strobe that begins or restarts a load.
- `cfg_valid` in 1: `cfg_data` is valid this cycle.
- `cfg_ready` out 1: the loader accepts a word this cycle.
- `cfg_data` in 6: signed two's-complement weight word.
- `loaded` out 1: the bank holds a complete, consistent weight set.
- `range_err` out 1: sticky flag; an n2 word did not fit in 4 bits.
- `weights_n1_mag` out [N2-1:0][N1/2:0][5:0]: first-layer magnitude weights.
- `weights_n1_pol` out [N2-1:0][N1/2:0][5:0]: first-layer polarity weights.
- `weights_n2` out [N2:0][3:0]: output-layer weights.

## Operation
- States are IDLE, LOAD_MAG, LOAD_POL, LOAD_N2 and DONE.
- A beat is a cycle with `cfg_valid && cfg_ready`. `cfg_ready` is 1 only in the three LOAD states.
- Load order: index n runs 0..N2-1 as the outer loop; index i runs 0..N1/2 as the inner loop.
  - Beat k of LOAD_MAG writes `weights_n1_mag[n][i]`.
  - LOAD_POL writes `weights_n1_pol` in the same order.
  - LOAD_N2 writes `weights_n2[j]` for j = 0..N2.
  - Total: 500 + 500 + 11 = 1011 beats.
- n2 width rule:
  - Store `cfg_data[3:0]`.
  - If `cfg_data[5:4] != {2{cfg_data[3]}}`, set `range_err`. There is no saturation.
  - `range_err` clears only on reset or `cfg_start`.
- Transitions:
  - IDLE or DONE plus `cfg_start`: go to LOAD_MAG, clear counters, clear `loaded`.
  - LOAD_MAG to LOAD_POL on the beat where n=N2-1 and i=N1/2.
  - LOAD_POL to LOAD_N2 on the analogous final beat.
  - LOAD_N2 to DONE on the beat where j=N2. `loaded` is set with the DONE entry.
- `cfg_start` in any LOAD state restarts at LOAD_MAG with counters at 0. Registers keep stale contents until overwritten. `loaded` stays 0.
- `cfg_start` coincident with a beat: the start wins and the beat is discarded (not written).
- `cfg_valid` outside the LOAD states is ignored.
- Reset, including mid-load: state IDLE, all weight registers 0, `loaded`=0, `range_err`=0, `cfg_ready`=0.

## Timing
- `cfg_start` sampled at edge 0 gives `cfg_ready`=1 from cycle 1.
- A written weight is visible on the outputs the cycle after its beat.
- With `cfg_valid` held high, the beats fall on cycles 1..1011. `loaded`=1 and `cfg_ready`=0 from cycle 1012.
- Back-pressure: when `cfg_valid` drops, the counters hold. There is no timeout.
- `cfg_ready` is a registered function of state only. It does not depend combinationally on `cfg_valid`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `dnd_pkg` holds:
  - `N1`, `N2`.
  - `W1_BITS`=6 and `W2_BITS`=4.
  - The `loader_state_t` enum.
  - Typedefs `w1_vec_t` ([N2-1:0][N1/2:0][5:0]) and `w2_vec_t` ([N2:0][3:0]).
- Sub-module `weight_index_ctr` holds the nested n/i (or j) counter. It has clear and enable inputs and a `wrap` output that pulses on the final index. The FSM and the bank decode sit in `weight_loader`.

## Test plan
- Reset then idle: all outputs 0, `cfg_ready`=0. `cfg_valid`=1 with data 6'd5 for 10 cycles changes nothing.
- Full load with continuous valid and a known pattern: `weights_n1_mag[3][7]`=-6'd3, `weights_n1_pol[9][49]`=6'd14, `weights_n2[10]`=4'd2 (all other words 0) → bank matches exactly, `loaded` rises at cycle 1012.
- Random `cfg_valid` gaps (30% idle) → same final bank. The beat count is exactly 1011 and `cfg_ready` drops the cycle after the last beat.
- n2 word 6'd9 → stored 4'b1001 and `range_err`=1. A following load with all n2 words in -8..7 keeps the flag until the next `cfg_start`, which clears it.
- `cfg_start` on beat 600 (mid LOAD_POL), coincident with valid → beat dropped, restart at `weights_n1_mag[0][0]`, `loaded` stays 0 until 1011 further beats complete.
- `rst_n`=0 at beat 1005 → bank zeroed, state IDLE next cycle, `loaded`=0.

Source files
------------

// File: rtl/dnd_pkg.sv
// Shared constants and types for the DND MLP weight path.
// The weight vector typedefs match the packed shapes the datapath consumes.
package dnd_pkg;

    localparam int N1      = 98;
    localparam int N2      = 10;
    localparam int W1_BITS = 6;
    localparam int W2_BITS = 4;

    localparam int N_BITS = $clog2(N2);
    localparam int I_BITS = $clog2(N1 / 2 + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAG,
        LOAD_POL,
        LOAD_N2,
        DONE
    } loader_state_t;

    typedef logic [N2-1:0][N1/2:0][W1_BITS-1:0] w1_vec_t;
    typedef logic [N2:0][W2_BITS-1:0]           w2_vec_t;

    // A 6-bit word fits the 4-bit n2 field when its top bits are sign copies.
    function automatic logic n2_fits(input logic [W1_BITS-1:0] d);
        return d[5:4] == {2{d[3]}};
    endfunction

endpackage

// File: rtl/weight_index_ctr.sv
// Nested outer/inner index counter with run-time limits.
// Wraps both indices to zero on the enabled final beat; wrap flags that beat.
module weight_index_ctr #(
    parameter int OW = 4,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [OW-1:0] outer_max,
    input  logic [IW-1:0] inner_max,
    output logic [OW-1:0] outer_q,
    output logic [IW-1:0] inner_q,
    output logic          wrap
);

    logic [OW-1:0] outer_d;
    logic [IW-1:0] inner_d;
    logic          outer_last;
    logic          inner_last;

    assign outer_last = (outer_q == outer_max);
    assign inner_last = (inner_q == inner_max);
    assign wrap       = outer_last && inner_last;

    always_comb begin
        outer_d = outer_q;
        inner_d = inner_q;
        if (clr) begin
            outer_d = '0;
            inner_d = '0;
        end else if (en) begin
            if (inner_last) begin
                inner_d = '0;
                outer_d = outer_last ? '0 : outer_q + OW'(1);
            end else begin
                inner_d = inner_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outer_q <= '0;
            inner_q <= '0;
        end else begin
            outer_q <= outer_d;
            inner_q <= inner_d;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Run-time weight store: streams signed words over a valid/ready port into
// the mag, pol and n2 banks in that order, then flags the set as loaded.
module weight_loader
    import dnd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [W1_BITS-1:0] cfg_data,
    output logic               loaded,
    output logic               range_err,
    output w1_vec_t            weights_n1_mag,
    output w1_vec_t            weights_n1_pol,
    output w2_vec_t            weights_n2
);

    loader_state_t state_q, state_d;
    logic          ready_q, ready_d;
    logic          loaded_q, loaded_d;
    logic          range_err_q, range_err_d;
    w1_vec_t       mag_q, mag_d;
    w1_vec_t       pol_q, pol_d;
    w2_vec_t       n2_q, n2_d;

    logic              beat;
    logic              wrap;
    logic [N_BITS-1:0] n_idx;
    logic [I_BITS-1:0] i_idx;
    logic [N_BITS-1:0] outer_max;
    logic [I_BITS-1:0] inner_max;

    // A start coincident with a beat wins; the beat's word is discarded.
    assign beat = cfg_valid && ready_q && !cfg_start;

    // The n2 phase reuses the inner index as j with a single outer pass.
    assign outer_max = (state_q == LOAD_N2) ? '0 : N_BITS'(N2 - 1);
    assign inner_max = (state_q == LOAD_N2) ? I_BITS'(N2) : I_BITS'(N1 / 2);

    weight_index_ctr #(
        .OW (N_BITS),
        .IW (I_BITS)
    ) u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cfg_start),
        .en        (beat),
        .outer_max (outer_max),
        .inner_max (inner_max),
        .outer_q   (n_idx),
        .inner_q   (i_idx),
        .wrap      (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_start) begin
            state_d = LOAD_MAG;
        end else if (beat && wrap) begin
            unique case (state_q)
                LOAD_MAG: state_d = LOAD_POL;
                LOAD_POL: state_d = LOAD_N2;
                LOAD_N2:  state_d = DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Flags are decoded from the next state so they are registered, not combinational.
    always_comb begin
        ready_d  = (state_d == LOAD_MAG) || (state_d == LOAD_POL) || (state_d == LOAD_N2);
        loaded_d = (state_d == DONE);
    end

    always_comb begin
        mag_d       = mag_q;
        pol_d       = pol_q;
        n2_d        = n2_q;
        range_err_d = range_err_q;
        if (cfg_start) begin
            range_err_d = 1'b0;
        end
        if (beat) begin
            unique case (state_q)
                LOAD_MAG: mag_d[n_idx][i_idx] = cfg_data;
                LOAD_POL: pol_d[n_idx][i_idx] = cfg_data;
                LOAD_N2: begin
                    n2_d[i_idx[3:0]] = cfg_data[W2_BITS-1:0];
                    if (!n2_fits(cfg_data)) begin
                        range_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            loaded_q    <= 1'b0;
            range_err_q <= 1'b0;
            mag_q       <= '0;
            pol_q       <= '0;
            n2_q        <= '0;
        end else begin
            ready_q     <= ready_d;
            loaded_q    <= loaded_d;
            range_err_q <= range_err_d;
            mag_q       <= mag_d;
            pol_q       <= pol_d;
            n2_q        <= n2_d;
        end
    end

    assign cfg_ready      = ready_q;
    assign loaded         = loaded_q;
    assign range_err      = range_err_q;
    assign weights_n1_mag = mag_q;
    assign weights_n1_pol = pol_q;
    assign weights_n2     = n2_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: drives weight streams, scoreboards every written
// word against an independent bank model, and checks the control flags.
module tb_weight_loader;
    import dnd_pkg::*;

    localparam int W     = 18;
    localparam int BEATS = 1011;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    cfg_start;
    logic    cfg_valid;
    logic    cfg_ready;
    logic [5:0] cfg_data;
    logic    loaded;
    logic    range_err;
    w1_vec_t weights_n1_mag;
    w1_vec_t weights_n1_pol;
    w2_vec_t weights_n2;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [5:0]   src_w[BEATS];
    w1_vec_t      exp_mag;
    w1_vec_t      exp_pol;
    w2_vec_t      exp_n2;
    logic         exp_ready;
    logic         exp_loaded;
    logic         exp_range_err;

    always #5 clk = ~clk;

    weight_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_data       (cfg_data),
        .loaded         (loaded),
        .range_err      (range_err),
        .weights_n1_mag (weights_n1_mag),
        .weights_n1_pol (weights_n1_pol),
        .weights_n2     (weights_n2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_ctrl(input string tag);
        check({tag, " cfg_ready"}, 32'(cfg_ready), 32'(exp_ready));
        check({tag, " loaded"}, 32'(loaded), 32'(exp_loaded));
        check({tag, " range_err"}, 32'(range_err), 32'(exp_range_err));
    endtask

    task automatic check_bank(input string tag);
        for (int n = 0; n < N2; n++) begin
            for (int i = 0; i <= N1 / 2; i++) begin
                check($sformatf("%s mag[%0d][%0d]", tag, n, i),
                      32'(weights_n1_mag[4'(n)][6'(i)]), 32'(exp_mag[4'(n)][6'(i)]));
                check($sformatf("%s pol[%0d][%0d]", tag, n, i),
                      32'(weights_n1_pol[4'(n)][6'(i)]), 32'(exp_pol[4'(n)][6'(i)]));
            end
        end
        for (int j = 0; j <= N2; j++) begin
            check($sformatf("%s n2[%0d]", tag, j), 32'(weights_n2[4'(j)]), 32'(exp_n2[4'(j)]));
        end
    endtask

    function automatic logic [W-1:0] addr_of(input int k, input logic [5:0] d);
        logic [1:0] kind;
        int         r;
        int         n;
        int         i;
        kind = (k < 500) ? 2'd0 : (k < 1000) ? 2'd1 : 2'd2;
        r    = (k < 500) ? k : (k < 1000) ? k - 500 : k - 1000;
        n    = (kind == 2'd2) ? 0 : r / 50;
        i    = (kind == 2'd2) ? r : r % 50;
        return {kind, 4'(n), 6'(i), d};
    endfunction

    task automatic model_reset();
        exp_mag       = '0;
        exp_pol       = '0;
        exp_n2        = '0;
        exp_ready     = 1'b0;
        exp_loaded    = 1'b0;
        exp_range_err = 1'b0;
    endtask

    task automatic pattern_a();
        for (int k = 0; k < BEATS; k++) src_w[k] = 6'd0;
        src_w[3 * 50 + 7]        = 6'b111101;
        src_w[500 + 9 * 50 + 49] = 6'd14;
        src_w[1010]              = 6'd2;
    endtask

    task automatic pattern_rand(input bit bad_n2);
        logic [3:0] v;
        for (int k = 0; k < 1000; k++) src_w[k] = 6'($urandom_range(0, 63));
        for (int k = 1000; k < BEATS; k++) begin
            v        = 4'($urandom_range(0, 15));
            src_w[k] = {{2{v[3]}}, v};
        end
        if (bad_n2) src_w[1003] = 6'd9;
    endtask

    task automatic send_start();
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        tick();
        cfg_start     = 1'b0;
        exp_ready     = 1'b1;
        exp_loaded    = 1'b0;
        exp_range_err = 1'b0;
        check_ctrl("start");
    endtask

    task automatic idle_valid(input string tag);
        cfg_valid = 1'b1;
        cfg_data  = 6'd5;
        repeat (10) begin
            tick();
            check_ctrl(tag);
        end
        cfg_valid = 1'b0;
        check_bank(tag);
    endtask

    // stop_kind: 0 none, 1 cfg_start on beat stop_at, 2 reset on beat stop_at.
    task automatic run_beats(input int idle_pct, input int stop_at, input int stop_kind);
        logic [W-1:0] e;
        logic [1:0]   kind;
        logic [3:0]   n;
        logic [5:0]   i;
        logic [5:0]   d;
        for (int k = 0; k < BEATS; k++) begin
            while (int'($urandom_range(0, 99)) < idle_pct) begin
                cfg_valid = 1'b0;
                cfg_data  = 6'($urandom);
                tick();
                check_ctrl("gap");
            end
            cfg_valid = 1'b1;
            cfg_data  = src_w[k];
            if (k == stop_at && stop_kind == 1) begin
                cfg_start = 1'b1;
                tick();
                cfg_start     = 1'b0;
                cfg_valid     = 1'b0;
                exp_range_err = 1'b0;
                check_ctrl("restart");
                e = addr_of(k, src_w[k]);
                check("dropped beat pol", 32'(weights_n1_pol[e[15:12]][e[11:6]]),
                      32'(exp_pol[e[15:12]][e[11:6]]));
                return;
            end
            if (k == stop_at && stop_kind == 2) begin
                rst_n = 1'b0;
                tick();
                rst_n     = 1'b1;
                cfg_valid = 1'b0;
                model_reset();
                check_ctrl("mid reset");
                check_bank("mid reset");
                return;
            end
            exp_q.push_back(addr_of(k, src_w[k]));
            tick();
            e    = exp_q.pop_front();
            kind = e[17:16];
            n    = e[15:12];
            i    = e[11:6];
            d    = e[5:0];
            case (kind)
                2'd0: begin
                    check($sformatf("beat %0d mag", k), 32'(weights_n1_mag[n][i]), 32'(d));
                    exp_mag[n][i] = d;
                end
                2'd1: begin
                    check($sformatf("beat %0d pol", k), 32'(weights_n1_pol[n][i]), 32'(d));
                    exp_pol[n][i] = d;
                end
                default: begin
                    check($sformatf("beat %0d n2", k), 32'(weights_n2[i[3:0]]), 32'(d[3:0]));
                    exp_n2[i[3:0]] = d[3:0];
                    if (d[5:4] != {d[3], d[3]}) exp_range_err = 1'b1;
                end
            endcase
            if (k == BEATS - 1) begin
                exp_ready  = 1'b0;
                exp_loaded = 1'b1;
            end
            check_ctrl($sformatf("beat %0d", k));
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 6'd0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_ctrl("reset");
        check_bank("reset");

        idle_valid("idle valid");

        pattern_a();
        send_start();
        run_beats(0, -1, 0);
        check_bank("load a");

        pattern_a();
        send_start();
        run_beats(30, -1, 0);
        check_bank("gaps a");

        pattern_rand(1'b1);
        send_start();
        run_beats(30, -1, 0);
        check("n2[3] stored", 32'(weights_n2[3]), 32'(4'b1001));
        check_bank("bad n2");
        repeat (5) begin
            tick();
            check_ctrl("done hold");
        end

        pattern_rand(1'b0);
        send_start();
        run_beats(30, -1, 0);
        check_bank("good n2");

        pattern_rand(1'b0);
        src_w[600] = ~exp_pol[2][0];
        send_start();
        run_beats(0, 600, 1);
        pattern_rand(1'b0);
        run_beats(0, -1, 0);
        check_bank("after restart");

        pattern_rand(1'b1);
        send_start();
        run_beats(0, 1005, 2);
        idle_valid("post reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
